// File: rtl/riscv_dmem_responder.sv
// Load/store responder for the core's data port: one request at a time,
// programmable wait, then an extended load result or an error flag.
module riscv_dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [AW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic              w_f3_ok;
  logic              w_misalign;
  logic              w_oor;
  logic              w_err;
  logic [DATA_W-1:0] w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic              w_enter_resp;
  logic              w_do_write;

  assign w_idx        = r_addr[AW+1:2];
  assign w_lane       = r_addr[1:0];
  assign w_enter_resp = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_do_write   = w_enter_resp && r_we && !w_err;

  // Legality is decided from the latched request; funct3[1:0] encodes width.
  always_comb begin
    w_f3_ok = 1'b0;
    case (r_funct3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !r_we;
      default:                w_f3_ok = 1'b0;
    endcase
    w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                 ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    w_oor      = (r_addr >= ADDR_LIMIT);
    w_err      = !w_f3_ok || w_misalign || w_oor;
  end

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load = w_word;
    case (r_funct3)
      3'b000:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    w_be        = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  // RAM is deliberately outside the reset domain so stores survive reset.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  // Counter loads LATENCY so RESP is entered LATENCY+1 edges after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_cnt       <= 4'(LATENCY);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rsp_valid <= 1'b1;
            r_err       <= w_err;
            r_rdata     <= (!r_we && !w_err) ? w_load : '0;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_riscv_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  riscv_dmem_responder #(.DATA_W(32), .DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response with rsp_ready high; lat counts edges from accept to rsp_valid.
  task automatic txn(input int sel, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int lat);
    logic rv;
    @(negedge clk);
    if (sel == 0) begin
      a_req_valid = 1'b1; a_req_we = we; a_req_funct3 = f3; a_req_addr = addr; a_req_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_req_we = we; b_req_funct3 = f3; b_req_addr = addr; b_req_wdata = wdata;
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    rv  = 1'b0;
    while (!rv && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      rv = (sel == 0) ? a_rsp_valid : b_rsp_valid;
    end
    rdata = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    err   = (sel == 0) ? a_rsp_err : b_rsp_err;
    $display("txn lat_inst=%0d we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             sel, we, f3, addr, wdata, rdata, err, lat);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_funct3 = 3'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0; b_req_addr = '0; b_req_wdata = '0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    check("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst_rsp_err",   {31'b0, a_rsp_err}, 32'd0);

    // Word store then the full set of load widths against it
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lt);
    check("sw_lat", lt, 3); check("sw_err", {31'b0, er}, 0); check("sw_rdata", rd, 0);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
    check("lw_lat", lt, 3); check("lw_data", rd, 32'hDEADBEEF); check("lw_err", {31'b0, er}, 0);
    txn(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er, lt);
    check("lb_13", rd, 32'hFFFFFFDE);
    txn(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er, lt);
    check("lbu_13", rd, 32'h000000DE);
    txn(0, 1'b0, 3'b001, 32'h12, 32'h0, rd, er, lt);
    check("lh_12", rd, 32'hFFFFDEAD);
    txn(0, 1'b0, 3'b101, 32'h10, 32'h0, rd, er, lt);
    check("lhu_10", rd, 32'h0000BEEF);

    txn(0, 1'b1, 3'b000, 32'h11, 32'h00000055, rd, er, lt);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
    check("sb_merge", rd, 32'hDEAD55EF);

    // Error cases
    txn(0, 1'b0, 3'b010, 32'h12, 32'h0, rd, er, lt);
    check("lw_mis_err", {31'b0, er}, 1); check("lw_mis_rdata", rd, 0);
    txn(0, 1'b1, 3'b010, 32'h0C, 32'h12345678, rd, er, lt);
    txn(0, 1'b1, 3'b001, 32'h0F, 32'h0000FFFF, rd, er, lt);
    check("sh_mis_err", {31'b0, er}, 1);
    txn(0, 1'b1, 3'b100, 32'h0C, 32'hFFFFFFFF, rd, er, lt);
    check("st_f3_err", {31'b0, er}, 1);
    txn(0, 1'b0, 3'b010, 32'h0C, 32'h0, rd, er, lt);
    check("word_0c_kept", rd, 32'h12345678);
    txn(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er, lt);
    check("f3_011_err", {31'b0, er}, 1); check("f3_011_rdata", rd, 0);
    txn(0, 1'b0, 3'b010, 32'h400, 32'h0, rd, er, lt);
    check("oor_err", {31'b0, er}, 1);
    txn(0, 1'b1, 3'b010, 32'h3FC, 32'h0BADF00D, rd, er, lt);
    txn(0, 1'b0, 3'b010, 32'h3FC, 32'h0, rd, er, lt);
    check("last_word", rd, 32'h0BADF00D); check("last_word_err", {31'b0, er}, 0);
    txn(0, 1'b1, 3'b001, 32'h0E, 32'h5555ABCD, rd, er, lt);
    txn(0, 1'b0, 3'b010, 32'h0C, 32'h0, rd, er, lt);
    check("sh_upper", rd, 32'hABCD5678);

    // Backpressure: hold the response while a stray request is offered
    a_rsp_ready = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_funct3 = 3'b010; a_req_addr = 32'h10;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    lt = 0;
    while (!a_rsp_valid && lt < 50) begin
      @(posedge clk); #1;
      lt++;
    end
    check("bp_lat", lt, 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'b010;
      a_req_addr = 32'h10; a_req_wdata = 32'h0;
      @(posedge clk); #1;
      check("bp_valid", {31'b0, a_rsp_valid}, 1);
      check("bp_rdata", a_rsp_rdata, 32'hDEAD55EF);
      check("bp_req_ready", {31'b0, a_req_ready}, 0);
    end
    $display("txn backpressure LW 0x10 held 5 cycles rdata=%h", a_rsp_rdata);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'b0, a_rsp_valid}, 0);
    check("bp_release_ready", {31'b0, a_req_ready}, 1);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er, lt);
    check("bp_no_store", rd, 32'hDEAD55EF);

    // Reset during WAIT discards a pending store
    txn(0, 1'b1, 3'b010, 32'h20, 32'h11111111, rd, er, lt);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_funct3 = 3'b010;
    a_req_addr = 32'h20; a_req_wdata = 32'h22222222;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("wait_req_ready", {31'b0, a_req_ready}, 0);
    @(negedge clk);
    reset = 1'b1; #1;
    check("mid_rst_req_ready", {31'b0, a_req_ready}, 1);
    check("mid_rst_rsp_valid", {31'b0, a_rsp_valid}, 0);
    check("mid_rst_rdata", a_rsp_rdata, 0);
    check("mid_rst_err", {31'b0, a_rsp_err}, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold_valid", {31'b0, a_rsp_valid}, 0);
    @(negedge clk); reset = 1'b0;
    $display("txn reset asserted during WAIT of SW 0x20");
    txn(0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er, lt);
    check("rst_discard", rd, 32'h11111111);

    // Zero-latency instance
    txn(1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D, rd, er, lt);
    check("l0_sw_lat", lt, 1);
    txn(1, 1'b0, 3'b010, 32'h40, 32'h0, rd, er, lt);
    check("l0_lw_lat", lt, 1); check("l0_lw_data", rd, 32'hCAFEF00D);
    txn(1, 1'b0, 3'b100, 32'h41, 32'h0, rd, er, lt);
    check("l0_lbu_41", rd, 32'h000000F0);
    txn(1, 1'b0, 3'b001, 32'h42, 32'h0, rd, er, lt);
    check("l0_lh_42", rd, 32'hFFFFCAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
